muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between a requester and muldiv_unit
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  fun_c;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, fun_c, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, fun_c, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - 32-bit iterative multiply/divide, fixed 33-cycle latency
// MULDIV_DIV_EN adds divu/div; without it divide requests are ignored.
module muldiv_unit (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        res_neg;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        start_ok;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [63:0] prod_fix;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

`ifdef MULDIV_DIV_EN
  logic        op_div;
  logic        a_neg;
  logic        b_zero;
  logic [33:0] trial;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`endif

  assign a_neg_in = bus.fun_c[0] & bus.a[31];
  assign b_neg_in = bus.fun_c[0] & bus.b[31];
  assign a_mag    = a_neg_in ? (32'd0 - bus.a) : bus.a;
  assign b_mag    = b_neg_in ? (32'd0 - bus.b) : bus.b;

`ifdef MULDIV_DIV_EN
  assign start_ok = bus.start;
`else
  assign start_ok = bus.start & ~bus.fun_c[1];
`endif

  // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign prod_fix = res_neg ? (64'd0 - acc) : acc;

`ifdef MULDIV_DIV_EN
  // Partial remainder kept 33 bits wide so remainders >= 2^31 shift without loss.
  assign trial    = {1'b0, acc[63:31]} - {2'b00, opb};
  assign div_next = trial[33] ? {acc[62:0], 1'b0}
                              : {trial[31:0], acc[30:0], 1'b1};
  assign step_next = op_div ? div_next : mul_next;

  // Zero divisor yields an all-ones quotient and the dividend as remainder.
  assign quo_fix = b_zero  ? 32'hFFFF_FFFF
                 : res_neg ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem_fix = a_neg ? (32'd0 - acc[63:32]) : acc[63:32];
  assign hi_res  = op_div ? rem_fix : prod_fix[63:32];
  assign lo_res  = op_div ? quo_fix : prod_fix[31:0];
`else
  assign step_next = mul_next;
  assign hi_res    = prod_fix[63:32];
  assign lo_res    = prod_fix[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      acc     <= 64'd0;
      opb     <= 32'd0;
      res_neg <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MULDIV_DIV_EN
      op_div  <= 1'b0;
      a_neg   <= 1'b0;
      b_zero  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt     <= 5'd0;
            acc     <= {32'd0, a_mag};
            opb     <= b_mag;
            res_neg <= a_neg_in ^ b_neg_in;
            busy_q  <= 1'b1;
            state   <= RUN;
`ifdef MULDIV_DIV_EN
            op_div  <= bus.fun_c[1];
            a_neg   <= a_neg_in;
            b_zero  <= (bus.b == 32'd0);
`endif
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIN;
          end
        end
        FIN: begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
